// File: rtl/operand_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_unit_pkg
//   Shared definitions for the operand fetch unit and its scoreboard.
//   - REG_ADDR_W / NUM_REGS : integer register file geometry
//   - reg_idx_t             : register index type
//   - operand_bundle_t      : what the output stage hands to execute
//   - decoded_req_t         : fields of a decoded instruction as seen here
//   - wb_hits()             : "writeback this cycle targets register idx"
//   The struct widths follow the default DATA_WIDTH / PC_WIDTH of the unit.
// -----------------------------------------------------------------------------
package operand_fetch_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] op1;
        logic [DATA_W_DEF-1:0] op2;
        reg_idx_t              rd;
        logic                  wr_rd;
        logic [PC_W_DEF-1:0]   pc;
    } operand_bundle_t;

    typedef struct packed {
        reg_idx_t            rs1;
        reg_idx_t            rs2;
        reg_idx_t            rd;
        logic                use_rs1;
        logic                use_rs2;
        logic                wr_rd;
        logic [PC_W_DEF-1:0] pc;
    } decoded_req_t;

    // x0 is hardwired, so a writeback to it never produces a usable value.
    function automatic logic wb_hits(input logic     we,
                                     input reg_idx_t wb_idx,
                                     input reg_idx_t idx);
        return we && (wb_idx != '0) && (wb_idx == idx);
    endfunction

endpackage

// File: rtl/operand_fetch_unit_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   One busy bit per integer register: set when an instruction that will
//   write the register issues, cleared when its writeback arrives.
//   Ports:
//     clk, rst (async, active-low)
//     flush               : clears every bit on the next edge (highest priority)
//     set_en / set_idx    : mark a register as having a pending write
//     clr_en / clr_idx    : writeback retires the pending write
//     look_a/b/c_idx      : three combinational lookup indices
//     busy_a/b/c          : busy bit of the corresponding index (registered)
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import operand_fetch_unit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t look_a_idx,
    input  reg_idx_t look_b_idx,
    input  reg_idx_t look_c_idx,
    output logic     busy_a,
    output logic     busy_b,
    output logic     busy_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear is applied before set so that a register re-claimed in the same
    // cycle its previous write retires stays busy for the new writer.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_a = busy_q[look_a_idx];
    assign busy_b = busy_q[look_b_idx];
    assign busy_c = busy_q[look_c_idx];

endmodule

// File: rtl/operand_fetch_unit.sv
// -----------------------------------------------------------------------------
// operand_fetch_unit
//   Reads source operands for decoded instructions from the integer register
//   file, stalls on RAW/WAW hazards against pending writes, bypasses the
//   current writeback and presents operands to execute from a one-entry
//   registered output stage (1-cycle latency from accept).
//
//   Handshakes (both sides): a transfer happens on a rising edge where
//   valid && ready are both 1. A producer holds valid and its payload stable
//   until the transfer. in_ready is computed without looking at in_valid;
//   out_valid and the out_* payload are registered and held while out_ready=0.
//
//   Ports:
//     clk, rst (async, active-low), flush (sync, drops everything in flight)
//     in_*        : decoded instruction (rs1, rs2, rd, use/write flags, pc)
//     rf_raddr*   : register file read addresses (combinational from in_rs*)
//     rf_rdata*   : register file combinational read data
//     wb_*        : writeback port shared with the register file
//     out_*       : operand bundle to execute
// -----------------------------------------------------------------------------
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int PC_WIDTH   = PC_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [4:0]            in_rd,
    input  logic                  in_use_rs1,
    input  logic                  in_use_rs2,
    input  logic                  in_wr_rd,
    input  logic [PC_WIDTH-1:0]   in_pc,

    output logic [4:0]            rf_raddr1,
    output logic [4:0]            rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,

    input  logic                  wb_regWrite,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_wdata,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [4:0]            out_rd,
    output logic                  out_wr_rd,
    output logic [PC_WIDTH-1:0]   out_pc
);

    logic                  busy_rs1;
    logic                  busy_rs2;
    logic                  busy_rd;
    logic                  wb_hit1;
    logic                  wb_hit2;
    logic                  raw1;
    logic                  raw2;
    logic                  waw;
    logic                  stage_free;
    logic                  accept;
    logic                  sb_set;
    logic                  sb_clr;
    logic [DATA_WIDTH-1:0] op1_sel;
    logic [DATA_WIDTH-1:0] op2_sel;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    // A writeback landing this cycle resolves a pending read of the same
    // register, so it both cancels the RAW stall and supplies the data.
    assign wb_hit1 = wb_hits(wb_regWrite, wb_rd, in_rs1);
    assign wb_hit2 = wb_hits(wb_regWrite, wb_rd, in_rs2);

    assign raw1 = in_use_rs1 && (in_rs1 != '0) && busy_rs1 && !wb_hit1;
    assign raw2 = in_use_rs2 && (in_rs2 != '0) && busy_rs2 && !wb_hit2;
    assign waw  = in_wr_rd && (in_rd != '0) && busy_rd &&
                  !(wb_regWrite && (wb_rd == in_rd));

    assign stage_free = !out_valid || out_ready;
    assign in_ready   = stage_free && !raw1 && !raw2 && !waw && !flush;
    assign accept     = in_valid && in_ready;

    assign sb_set = accept && in_wr_rd && (in_rd != '0);
    assign sb_clr = wb_regWrite && (wb_rd != '0);

    regfile_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .set_en     (sb_set),
        .set_idx    (in_rd),
        .clr_en     (sb_clr),
        .clr_idx    (wb_rd),
        .look_a_idx (in_rs1),
        .look_b_idx (in_rs2),
        .look_c_idx (in_rd),
        .busy_a     (busy_rs1),
        .busy_b     (busy_rs2),
        .busy_c     (busy_rd)
    );

    // Operands are captured even when the instruction does not use them;
    // execute simply ignores the unused one.
    always_comb begin
        op1_sel = rf_rdata1;
        if (in_rs1 == '0) begin
            op1_sel = '0;
        end else if (wb_hit1) begin
            op1_sel = wb_wdata;
        end
    end

    always_comb begin
        op2_sel = rf_rdata2;
        if (in_rs2 == '0) begin
            op2_sel = '0;
        end else if (wb_hit2) begin
            op2_sel = wb_wdata;
        end
    end

    // Output stage. While out_valid && !out_ready, accept is impossible
    // (stage_free=0), so the payload holds by falling through every branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_wr_rd <= 1'b0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op1   <= op1_sel;
            out_op2   <= op2_sel;
            out_rd    <= in_rd;
            out_wr_rd <= in_wr_rd;
            out_pc    <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch_unit
//   Drives decoded instructions and writebacks, keeps a register-value and
//   pending-write model, and checks in_ready every cycle plus every operand
//   bundle presented to execute against an expected queue.
// -----------------------------------------------------------------------------
module tb_operand_fetch_unit;
    import operand_fetch_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        flush;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_rs1, in_use_rs2, in_wr_rd;
    logic [31:0] in_pc;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_regWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_wr_rd;
    logic [31:0] out_pc;

    operand_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_use_rs1  (in_use_rs1),
        .in_use_rs2  (in_use_rs2),
        .in_wr_rd    (in_wr_rd),
        .in_pc       (in_pc),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .wb_regWrite (wb_regWrite),
        .wb_rd       (wb_rd),
        .wb_wdata    (wb_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_rd      (out_rd),
        .out_wr_rd   (out_wr_rd),
        .out_pc      (out_pc)
    );

    // ---------------- reference model state ----------------
    logic [31:0]     rf_m [32];   // architectural register contents
    logic [31:0]     pend_m;      // registers with a write still outstanding
    operand_bundle_t exp_q [$];   // bundles execute should see, in order
    int              n_cmp = 0;
    int              n_bad = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value register r holds once this cycle's writeback has landed.
    function automatic logic [31:0] reg_value(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_regWrite && wb_rd == r) return wb_wdata;
        return rf_m[r];
    endfunction

    // A source is blocked if it is read, not x0, and its value is still
    // outstanding after this cycle's writeback.
    function automatic logic src_blocked(input logic use_it, input logic [4:0] r);
        return use_it && r != 5'd0 && pend_m[r] && !(wb_regWrite && wb_rd == r);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_wr_rd = 1'b0; in_pc = '0;
        wb_regWrite = 1'b0; wb_rd = '0; wb_wdata = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic wr, input logic [31:0] pc);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_use_rs1 = u1; in_use_rs2 = u2; in_wr_rd = wr; in_pc = pc;
    endtask

    // Called at posedge+2 with inputs set; returns at the next posedge+2.
    task automatic step();
        logic            exp_ready;
        logic            acc;
        logic            blocked_rd;
        operand_bundle_t e;
        rf_rdata1 = rf_m[in_rs1];
        rf_rdata2 = rf_m[in_rs2];
        #1;
        blocked_rd = in_wr_rd && in_rd != 5'd0 && pend_m[in_rd] &&
                     !(wb_regWrite && wb_rd == in_rd);
        exp_ready = (exp_q.size() == 0 || out_ready) && !flush &&
                    !src_blocked(in_use_rs1, in_rs1) &&
                    !src_blocked(in_use_rs2, in_rs2) && !blocked_rd;
        check("in_ready", in_ready, exp_ready);
        check("rf_raddr", {rf_raddr1, rf_raddr2}, {in_rs1, in_rs2});
        acc = in_valid && exp_ready;
        e = '{op1: reg_value(in_rs1), op2: reg_value(in_rs2), rd: in_rd,
              wr_rd: in_wr_rd, pc: in_pc};
        @(posedge clk);
        if (flush) begin
            pend_m = '0;
            exp_q.delete();
        end else begin
            if (wb_regWrite && wb_rd != 5'd0) pend_m[wb_rd] = 1'b0;
            if (acc && in_wr_rd && in_rd != 5'd0) pend_m[in_rd] = 1'b1;
            if (acc) exp_q.push_back(e);
        end
        if (wb_regWrite && wb_rd != 5'd0) rf_m[wb_rd] = wb_wdata;
        #2;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                check("out_bundle", {out_op1, out_op2, out_rd, out_wr_rd, out_pc}, exp_q[0]);
                if (out_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 32; i++) rf_m[i] = $urandom;
        rf_m[0] = 32'h0000_FFFF;   // register file garbage on x0 must never leak
        pend_m = '0;
        set_idle();
        rf_rdata1 = '0; rf_rdata2 = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ops", {out_op1, out_op2}, 64'd0);
        check("rst_out_tags", {out_rd, out_wr_rd, out_pc}, 38'd0);
        rst = 1'b1;
        step();

        // Basic issue
        rf_m[3] = 32'h11; rf_m[4] = 32'h22;
        issue(5'd3, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 32'h100);
        step();
        check("basic_ops", {out_op1, out_op2}, {32'h11, 32'h22});
        set_idle();
        step();

        // RAW stall released by same-cycle writeback with bypass
        issue(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 32'h104);
        step();
        issue(5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h108);
        step();
        step();
        wb_regWrite = 1'b1; wb_rd = 5'd5; wb_wdata = 32'hDEAD;
        step();
        check("raw_bypass_op1", out_op1, 32'hDEAD);
        set_idle();
        step();

        // x0 handling
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h10C);
        step();
        check("x0_op1", out_op1, 32'd0);
        issue(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h110);
        step();
        set_idle();
        step();

        // Backpressure holds the stage
        issue(5'd3, 5'd4, 5'd8, 1'b1, 1'b1, 1'b0, 32'h200);
        step();
        out_ready = 1'b0;
        issue(5'd4, 5'd3, 5'd8, 1'b1, 1'b1, 1'b0, 32'h204);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", {out_op1, out_pc}, {32'h11, 32'h200});
        end
        out_ready = 1'b1;
        step();
        check("bp_release_pc", out_pc, 32'h204);
        set_idle();
        step();

        // Same-cycle set and clear on rd=7: set wins
        issue(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 32'h300);
        step();
        issue(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 32'h304);
        wb_regWrite = 1'b1; wb_rd = 5'd7; wb_wdata = 32'h7777;
        step();
        wb_regWrite = 1'b0;
        issue(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h308);
        step();
        step();
        wb_regWrite = 1'b1; wb_rd = 5'd7; wb_wdata = 32'h7878;
        step();
        set_idle();
        step();

        // Flush clears pending writes and the output stage
        issue(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 32'h400);
        step();
        set_idle();
        out_ready = 1'b0;
        step();
        flush = 1'b1;
        issue(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h404);
        step();
        check("flush_out_valid", out_valid, 1'b0);
        flush = 1'b0;
        out_ready = 1'b1;
        step();
        check("post_flush_pc", out_pc, 32'h404);
        set_idle();
        step();

        // Asynchronous reset mid-transfer
        issue(5'd3, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 32'h500);
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_op1", out_op1, 32'd0);
        exp_q.delete();
        pend_m = '0;
        set_idle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        step();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int start;
            in_valid    = ($urandom_range(0, 3) != 0);
            in_rs1      = 5'($urandom_range(0, 15));
            in_rs2      = 5'($urandom_range(0, 15));
            in_rd       = 5'($urandom_range(0, 15));
            in_use_rs1  = 1'($urandom_range(0, 1));
            in_use_rs2  = 1'($urandom_range(0, 1));
            in_wr_rd    = 1'($urandom_range(0, 1));
            in_pc       = $urandom;
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 63) == 0);
            wb_regWrite = 1'($urandom_range(0, 1));
            wb_wdata    = $urandom;
            wb_rd       = 5'($urandom_range(0, 15));
            start       = $urandom_range(0, 31);
            if (pend_m != 0 && $urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 32; k++) begin
                    if (pend_m[(start + k) % 32]) begin
                        wb_rd = 5'((start + k) % 32);
                        break;
                    end
                end
            end
            step();
        end

        // Drain
        set_idle();
        repeat (5) step();
        check("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
